// File: rtl/tt_host.sv
// tt_host: iopage initiator that polls the DL11 console registers and moves bytes between a
// TX FIFO, the DL11 and an RX holding register. Optional local echo: TT_HOST_ECHO_EN.
module tt_host #(
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_GAP   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [12:0] iopage_addr,
    output logic        iopage_rd,
    output logic        iopage_wr,
    output logic        iopage_byte_op,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    input  logic [7:0]  tx_char,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_char,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam bit            NO_GAP   = (POLL_GAP == 0);

    localparam logic [12:0] A_TTI_CSR = 13'o17560;
    localparam logic [12:0] A_TTI_DAT = 13'o17562;
    localparam logic [12:0] A_TTO_CSR = 13'o17564;
    localparam logic [12:0] A_TTO_DAT = 13'o17566;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX_CSR  = 3'd1,
        S_RX_DATA = 3'd2,
        S_TX_CSR  = 3'd3,
        S_TX_WR   = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_gap_cnt;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_echo_slot;
    logic            w_echo;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_push_data;
    logic [7:0]      w_head;
    logic            w_unused_din;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

`ifdef TT_HOST_ECHO_EN
    // The echo owns the FIFO write port for the whole RX_DATA cycle, even when it is dropped.
    assign w_echo_slot = (r_state == S_RX_DATA);
    assign w_echo      = w_echo_slot && !w_full;
`else
    assign w_echo_slot = 1'b0;
    assign w_echo      = 1'b0;
`endif

    assign tx_ready    = !w_full && !w_echo_slot;
    assign w_push      = w_echo || (tx_valid && tx_ready);
    assign w_push_data = w_echo ? data_in[7:0] : tx_char;
    assign w_pop       = (r_state == S_TX_WR);

    assign busy           = ((r_state != S_IDLE) && (r_state != S_GAP)) || !w_empty;
    assign iopage_byte_op = 1'b0;
    assign dbg_state      = r_state;
    assign w_unused_din   = ^data_in[15:8];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A load from RX_DATA takes precedence over a same-cycle consumer accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid <= 1'b0;
            rx_char  <= 8'h00;
        end else if (r_state == S_RX_DATA) begin
            rx_valid <= 1'b1;
            rx_char  <= data_in[7:0];
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // Bus outputs are registered with the state: each one describes the access of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_gap_cnt   <= '0;
            iopage_rd   <= 1'b0;
            iopage_wr   <= 1'b0;
            iopage_addr <= '0;
            data_out    <= '0;
        end else begin
            iopage_rd   <= 1'b0;
            iopage_wr   <= 1'b0;
            iopage_addr <= '0;
            data_out    <= '0;
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_RX_CSR;
                    iopage_rd   <= 1'b1;
                    iopage_addr <= A_TTI_CSR;
                end
                S_RX_CSR: begin
                    if (data_in[7] && !rx_valid) begin
                        r_state     <= S_RX_DATA;
                        iopage_rd   <= 1'b1;
                        iopage_addr <= A_TTI_DAT;
                    end else if (!w_empty) begin
                        r_state     <= S_TX_CSR;
                        iopage_rd   <= 1'b1;
                        iopage_addr <= A_TTO_CSR;
                    end else if (NO_GAP) begin
                        r_state     <= S_RX_CSR;
                        iopage_rd   <= 1'b1;
                        iopage_addr <= A_TTI_CSR;
                    end else begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                    end
                end
                S_RX_DATA: begin
                    if (!w_empty) begin
                        r_state     <= S_TX_CSR;
                        iopage_rd   <= 1'b1;
                        iopage_addr <= A_TTO_CSR;
                    end else if (NO_GAP) begin
                        r_state     <= S_RX_CSR;
                        iopage_rd   <= 1'b1;
                        iopage_addr <= A_TTI_CSR;
                    end else begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                    end
                end
                S_TX_CSR: begin
                    if (data_in[7]) begin
                        r_state     <= S_TX_WR;
                        iopage_wr   <= 1'b1;
                        iopage_addr <= A_TTO_DAT;
                        data_out    <= {8'h00, w_head};
                    end else if (NO_GAP) begin
                        r_state     <= S_RX_CSR;
                        iopage_rd   <= 1'b1;
                        iopage_addr <= A_TTI_CSR;
                    end else begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                    end
                end
                S_TX_WR: begin
                    if (NO_GAP) begin
                        r_state     <= S_RX_CSR;
                        iopage_rd   <= 1'b1;
                        iopage_addr <= A_TTI_CSR;
                    end else begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state     <= S_RX_CSR;
                        iopage_rd   <= 1'b1;
                        iopage_addr <= A_TTI_CSR;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_host.sv
// tb_tt_host: drives tt_host against a DL11 responder and checks every cycle against an
// access-schedule model; TT_HOST_ECHO_EN selects the echo build.
module tb_tt_host;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam logic [12:0] A_TTI_CSR = 13'o17560;
    localparam logic [12:0] A_TTI_DAT = 13'o17562;
    localparam logic [12:0] A_TTO_CSR = 13'o17564;
    localparam logic [12:0] A_TTO_DAT = 13'o17566;
`ifdef TT_HOST_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] iopage_addr;
    logic        iopage_rd;
    logic        iopage_wr;
    logic        iopage_byte_op;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic [7:0]  tx_char = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_char;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // DL11 responder and its stimulus knobs
    logic        dl_tti_rdy = 1'b0;
    logic [15:0] dl_tti_data = 16'h0;
    logic        dl_tto_rdy = 1'b1;
    int          dl_tto_cnt = 0;
    logic [15:0] dl_noise = 16'h0;
    logic        tto_hold = 1'b0;
    logic        rx_inject = 1'b0;
    logic [7:0]  rx_inject_char = 8'h00;
    logic        rx_rand_en = 1'b0;

    // Model: the access expected this cycle, the FIFO contents and the RX holding register
    logic        e_rd = 1'b0;
    logic        e_wr = 1'b0;
    logic [12:0] e_addr = 13'h0;
    logic [15:0] e_dout = 16'h0;
    logic [7:0]  exp_q[$];
    logic        m_rxv = 1'b0;
    logic [7:0]  m_rxc = 8'h00;
    int          m_quiet = 1;
    logic [7:0]  wr_log[$];
    int          rxd_cnt = 0;

    logic [15:0] din;
    logic        n_rd, n_wr, go_gap, go_poll, push_ok;
    logic [12:0] n_addr;
    logic [15:0] n_dout;

    tt_host #(.FIFO_DEPTH(DEPTH), .POLL_GAP(GAP)) dut (
        .clk(clk), .reset(reset),
        .iopage_addr(iopage_addr), .iopage_rd(iopage_rd), .iopage_wr(iopage_wr),
        .iopage_byte_op(iopage_byte_op), .data_out(data_out), .data_in(data_in),
        .tx_char(tx_char), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_char(rx_char), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dl_read(input logic rd, input logic [12:0] addr,
                                            input logic tti_rdy, input logic [15:0] tti_data,
                                            input logic tto_vis, input logic [15:0] noise);
        if (!rd) return 16'h0;
        case (addr)
            A_TTI_CSR: return {noise[15:8], tti_rdy, noise[6:0]};
            A_TTI_DAT: return tti_data;
            A_TTO_CSR: return {noise[15:8], tto_vis, noise[6:0]};
            default:   return 16'h0;
        endcase
    endfunction

    assign data_in = dl_read(iopage_rd, iopage_addr, dl_tti_rdy, dl_tti_data,
                             dl_tto_rdy && !tto_hold, dl_noise);

    function automatic logic exp_tx_ready();
        return (exp_q.size() < DEPTH) && !(ECHO && e_rd && e_addr == A_TTI_DAT);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o, expected %0o (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within its cycle budget (t=%0t)", name, $time);
    endtask

    // Model step: the next access follows from the access just made and the data it returned.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rd = 1'b0; e_wr = 1'b0; e_addr = 13'h0; e_dout = 16'h0;
            exp_q.delete();
            m_rxv = 1'b0; m_rxc = 8'h00; m_quiet = 1;
            dl_tti_rdy <= 1'b0;
            dl_tto_rdy <= 1'b1;
            dl_tto_cnt <= 0;
            dl_noise   <= 16'h0;
        end else begin
            din = dl_read(e_rd, e_addr, dl_tti_rdy, dl_tti_data, dl_tto_rdy && !tto_hold, dl_noise);
            push_ok = tx_valid && exp_tx_ready();
            n_rd = 1'b0; n_wr = 1'b0; n_addr = 13'h0; n_dout = 16'h0;
            go_gap = 1'b0; go_poll = 1'b0;
            if (e_rd && e_addr == A_TTI_CSR) begin
                if (din[7] && !m_rxv) begin n_rd = 1'b1; n_addr = A_TTI_DAT; end
                else if (exp_q.size() != 0) begin n_rd = 1'b1; n_addr = A_TTO_CSR; end
                else go_gap = 1'b1;
            end else if (e_rd && e_addr == A_TTI_DAT) begin
                if (exp_q.size() != 0) begin n_rd = 1'b1; n_addr = A_TTO_CSR; end
                else go_gap = 1'b1;
            end else if (e_rd && e_addr == A_TTO_CSR) begin
                if (din[7]) begin n_wr = 1'b1; n_addr = A_TTO_DAT; n_dout = {8'h00, exp_q[0]}; end
                else go_gap = 1'b1;
            end else if (e_wr) begin
                go_gap = 1'b1;
            end else begin
                m_quiet--;
                if (m_quiet == 0) go_poll = 1'b1;
            end
            if (go_gap) begin
                if (GAP == 0) go_poll = 1'b1;
                else m_quiet = GAP;
            end
            if (go_poll) begin n_rd = 1'b1; n_addr = A_TTI_CSR; end

            if (e_rd && e_addr == A_TTI_DAT) begin
                m_rxv = 1'b1;
                m_rxc = din[7:0];
                if (ECHO && exp_q.size() < DEPTH) exp_q.push_back(din[7:0]);
            end else if (m_rxv && rx_ready) begin
                m_rxv = 1'b0;
            end
            if (e_wr) void'(exp_q.pop_front());
            if (push_ok) exp_q.push_back(tx_char);

            // responder reacts to the access that just completed
            if (e_rd && e_addr == A_TTI_DAT) begin
                dl_tti_rdy <= 1'b0;
            end else if (!dl_tti_rdy && rx_inject) begin
                dl_tti_rdy  <= 1'b1;
                dl_tti_data <= {8'h00, rx_inject_char};
            end else if (!dl_tti_rdy && rx_rand_en && $urandom_range(0, 15) == 0) begin
                dl_tti_rdy  <= 1'b1;
                dl_tti_data <= 16'($urandom);
            end
            if (e_wr) begin
                dl_tto_rdy <= 1'b0;
                dl_tto_cnt <= $urandom_range(1, 10);
            end else if (dl_tto_cnt != 0) begin
                dl_tto_cnt <= dl_tto_cnt - 1;
                if (dl_tto_cnt == 1) dl_tto_rdy <= 1'b1;
            end
            dl_noise <= rx_rand_en ? 16'($urandom) : 16'h0;

            e_rd = n_rd; e_wr = n_wr; e_addr = n_addr; e_dout = n_dout;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (reset) begin
            chk("iopage_rd", 16'(iopage_rd), 16'(e_rd));
            chk("iopage_wr", 16'(iopage_wr), 16'(e_wr));
            chk("iopage_addr", 16'(iopage_addr), 16'(e_addr));
            chk("data_out", data_out, e_dout);
            chk("byte_op", 16'(iopage_byte_op), 16'h0);
            chk("tx_ready", 16'(tx_ready), 16'(exp_tx_ready()));
            chk("busy", 16'(busy), 16'(e_rd || e_wr || exp_q.size() != 0));
            chk("rx_valid", 16'(rx_valid), 16'(m_rxv));
            chk("rx_char", 16'(rx_char), 16'(m_rxc));
            if (iopage_wr) wr_log.push_back(data_out[7:0]);
            if (iopage_rd && iopage_addr == A_TTI_DAT) rxd_cnt++;
        end
    end

    task automatic push(input logic [7:0] c);
        tx_valid = 1'b1;
        tx_char  = c;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic inject(input logic [7:0] c);
        rx_inject_char = c;
        rx_inject = 1'b1;
        @(negedge clk);
        rx_inject = 1'b0;
    endtask

    task automatic wait_wr(input int max_cyc, input string name, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!iopage_wr && n < max_cyc);
        if (!iopage_wr) timeout(name);
    endtask

    task automatic wait_rx(input logic [7:0] c, input int max_cyc, input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(rx_valid && rx_char == c) && n < max_cyc);
        if (!(rx_valid && rx_char == c)) timeout(name);
    endtask

    task automatic wait_log(input int cnt, input int max_cyc, input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (wr_log.size() < cnt && n < max_cyc);
        if (wr_log.size() < cnt) timeout(name);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_addr", 16'(iopage_addr), 16'h0);
        chk("reset_strobes", 16'({iopage_rd, iopage_wr}), 16'h0);
        chk("reset_tx_ready", 16'(tx_ready), 16'h1);
        chk("reset_busy", 16'(busy), 16'h0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("first_poll_rd", 16'(iopage_rd), 16'h1);
        chk("first_poll_addr", 16'(iopage_addr), 16'(13'o17560));

        // single transmit, then spacing to the next write
        push(8'o101);
        wait_wr(60, "single_tx_wait", n);
        chk("single_tx_addr", 16'(iopage_addr), 16'(13'o17566));
        chk("single_tx_data", data_out, 16'o000101);
        push(8'o102);
        wait_wr(100, "second_tx_wait", n);
        chk("tx_spacing_ge6", 16'(n + 1 >= 6), 16'h1);
        repeat (20) @(negedge clk);

        // TTO busy: nothing goes out while the CSR reads 0000
        tto_hold = 1'b1;
        @(negedge clk);
        wr_log.delete();
        push(8'o103); push(8'o104); push(8'o105);
        repeat (20) @(negedge clk);
        chk("tto_busy_no_wr", 16'(wr_log.size()), 16'h0);
        chk("tto_busy_tx_ready", 16'(tx_ready), 16'h1);
        tto_hold = 1'b0;
        wait_log(3, 200, "tto_busy_drain");
        chk("order_0", 16'(wr_log.size() > 0 ? wr_log[0] : 8'h0), 16'o103);
        chk("order_1", 16'(wr_log.size() > 1 ? wr_log[1] : 8'h0), 16'o104);
        chk("order_2", 16'(wr_log.size() > 2 ? wr_log[2] : 8'h0), 16'o105);

        // FIFO full: fifth push is ignored
        tto_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1;
            tx_char  = 8'(8'o110 + i);
            @(negedge clk);
            if (i == 3) chk("full_tx_ready", 16'(tx_ready), 16'h0);
        end
        tx_valid = 1'b0;
        @(negedge clk);
        wr_log.delete();
        tto_hold = 1'b0;
        wait_log(4, 300, "full_drain");
        repeat (60) @(negedge clk);
        chk("full_write_count", 16'(wr_log.size()), 16'h4);
        chk("full_last_char", 16'(wr_log.size() > 3 ? wr_log[3] : 8'h0), 16'o113);

        // receive with backpressure
        rx_ready = 1'b0;
        inject(8'o141);
        wait_rx(8'o141, 60, "rx_first_wait");
        chk("rx_first_char", 16'(rx_char), 16'o141);
        rxd_cnt = 0;
        inject(8'o142);
        repeat (40) @(negedge clk);
        chk("rx_hold_no_data_read", 16'(rxd_cnt), 16'h0);
        chk("rx_hold_char", 16'(rx_char), 16'o141);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        wait_rx(8'o142, 60, "rx_second_wait");
        rx_ready = 1'b1;
        repeat (80) @(negedge clk);

`ifdef TT_HOST_ECHO_EN
        wr_log.delete();
        rx_ready = 1'b0;
        inject(8'o162);
        wait_log(1, 100, "echo_wait");
        chk("echo_data", 16'(wr_log.size() > 0 ? wr_log[0] : 8'h0), 16'o162);
        chk("echo_rx_char", 16'(rx_char), 16'o162);
        chk("echo_rx_valid", 16'(rx_valid), 16'h1);
        rx_ready = 1'b1;
        repeat (40) @(negedge clk);
        tto_hold = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready = 1'b0;
        push(8'o170); push(8'o171); push(8'o172); push(8'o173);
        inject(8'o163);
        wait_rx(8'o163, 60, "echo_full_rx_wait");
        wr_log.delete();
        tto_hold = 1'b0;
        wait_log(4, 300, "echo_full_drain");
        repeat (60) @(negedge clk);
        chk("echo_full_count", 16'(wr_log.size()), 16'h4);
        chk("echo_full_last", 16'(wr_log.size() > 3 ? wr_log[3] : 8'h0), 16'o173);
        rx_ready = 1'b1;
        repeat (20) @(negedge clk);
`endif

        // randomized traffic
        rx_rand_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_char  = 8'($urandom);
            rx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) tto_hold = ~tto_hold;
            @(negedge clk);
        end
        rx_rand_en = 1'b0;
        tto_hold = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        repeat (100) @(negedge clk);

        // reset in the middle of a TTO write
        push(8'o105);
        wait_wr(100, "midwr_wait", n);
        #2 reset = 1'b0;
        #1;
        chk("midwr_strobes", 16'({iopage_rd, iopage_wr}), 16'h0);
        chk("midwr_addr", 16'(iopage_addr), 16'h0);
        chk("midwr_data_out", data_out, 16'h0);
        chk("midwr_busy", 16'(busy), 16'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("post_reset_tx_ready", 16'(tx_ready), 16'h1);
        chk("post_reset_rx_valid", 16'(rx_valid), 16'h0);
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        timeout("watchdog");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
